// File: rtl/demux_1x4_3bit_latch_pkg.sv
// Shared encodings for the board switch/LED blocks: FSM states, button ops and bank indices.
package board_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PRESS_DB = 2'd1,
      COMMIT   = 2'd2,
      REL_DB   = 2'd3
   } state_t;

   typedef enum logic {
      OP_LOAD = 1'b0,
      OP_CLR  = 1'b1
   } op_t;

   localparam logic [1:0] BANK_X = 2'd0;
   localparam logic [1:0] BANK_Y = 2'd1;
   localparam logic [1:0] BANK_Z = 2'd2;
   localparam logic [1:0] BANK_W = 2'd3;

endpackage

// File: rtl/demux_1x4_3bit_latch_if.sv
// Board-side bundle for the 1x4 demux: switch/button inputs and held LED bank outputs.
interface demux_1x4_3bit_latch_if #(
   parameter int WIDTH = 3
);
   logic [WIDTH-1:0] D;
   logic [1:0]       S;
   logic             LOAD;
   logic             CLR;
   logic [WIDTH-1:0] X;
   logic [WIDTH-1:0] Y;
   logic [WIDTH-1:0] Z;
   logic [WIDTH-1:0] W;
   logic             S1LED;
   logic             S0LED;
   logic             WR_STB;
   logic             BUSY;

   modport master (
      output D, S, LOAD, CLR,
      input  X, Y, Z, W, S1LED, S0LED, WR_STB, BUSY
   );

   modport slave (
      input  D, S, LOAD, CLR,
      output X, Y, Z, W, S1LED, S0LED, WR_STB, BUSY
   );
endinterface

// File: rtl/demux_1x4_3bit_latch_sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs; q lags d by two clock edges.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_r;
   logic [WIDTH-1:0] q_r;

   // metastability stage followed by the stable output stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_r <= '0;
         q_r    <= '0;
      end else begin
         meta_r <= d;
         q_r    <= meta_r;
      end
   end

   assign q = q_r;

endmodule

// File: rtl/demux_1x4_3bit_latch.sv
// Debounced 1-to-4 demux: a LOAD press copies D into the bank picked by S, a CLR press zeroes
// all banks; each press commits once, after a clean press and before a clean release.
module demux_1x4_3bit_latch
   import board_pkg::*;
#(
   parameter int WIDTH        = 3,
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   demux_1x4_3bit_latch_if.slave   bus
);

   localparam int           CNT_W    = $clog2(DEBOUNCE_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   if (DEBOUNCE_CYC < 2) begin : g_bad_cfg
      $error("DEBOUNCE_CYC must be at least 2");
   end

   logic             rst_meta_r;
   logic             rst_sync_n_r;
   logic [WIDTH+1:0] data_sync_s;
   logic [1:0]       btn_sync_s;
   logic [WIDTH-1:0] d_s;
   logic [1:0]       sel_s;
   logic             load_s;
   logic             clr_s;
   logic             btn_s;

   state_t           state_r;
   state_t           next_state_s;
   op_t              op_r;
   op_t              op_next_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_next_s;
   logic             wr_stb_r;
   logic             busy_r;
   logic [WIDTH-1:0] bank_x_r;
   logic [WIDTH-1:0] bank_y_r;
   logic [WIDTH-1:0] bank_z_r;
   logic [WIDTH-1:0] bank_w_r;

   // reset synchroniser: assert asynchronously, release on a clock edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_meta_r   <= 1'b0;
         rst_sync_n_r <= 1'b0;
      end else begin
         rst_meta_r   <= 1'b1;
         rst_sync_n_r <= rst_meta_r;
      end
   end

   sync_2ff #(.WIDTH(WIDTH + 2)) u_sync_data (
      .clk   (clk),
      .rst_n (rst_sync_n_r),
      .d     ({bus.D, bus.S}),
      .q     (data_sync_s)
   );

   sync_2ff #(.WIDTH(2)) u_sync_btn (
      .clk   (clk),
      .rst_n (rst_sync_n_r),
      .d     ({bus.LOAD, bus.CLR}),
      .q     (btn_sync_s)
   );

   assign d_s    = data_sync_s[WIDTH+1:2];
   assign sel_s  = data_sync_s[1:0];
   assign load_s = btn_sync_s[1];
   assign clr_s  = btn_sync_s[0];
   assign btn_s  = (op_r == OP_CLR) ? clr_s : load_s;

   // next-state, op capture and debounce counter
   always_comb begin
      next_state_s = state_r;
      op_next_s    = op_r;
      cnt_next_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (clr_s) begin
               next_state_s = PRESS_DB;
               op_next_s    = OP_CLR;
            end else if (load_s) begin
               next_state_s = PRESS_DB;
               op_next_s    = OP_LOAD;
            end else begin
               next_state_s = IDLE;
            end
         end
         PRESS_DB: begin
            if (!btn_s) begin
               next_state_s = IDLE;
            end else if (cnt_r == CNT_LAST) begin
               next_state_s = COMMIT;
            end else begin
               cnt_next_s = cnt_r + CNT_W'(1);
            end
         end
         COMMIT: begin
            next_state_s = REL_DB;
         end
         REL_DB: begin
            if (load_s || clr_s) begin
               cnt_next_s = '0;
            end else if (cnt_r == CNT_LAST) begin
               next_state_s = IDLE;
            end else begin
               cnt_next_s = cnt_r + CNT_W'(1);
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
      // every state change restarts the debounce count
      if (next_state_s != state_r) begin
         cnt_next_s = '0;
      end else begin
         cnt_next_s = cnt_next_s;
      end
   end

   // FSM registers; strobe and busy are registered from next state so they align with state_r
   always_ff @(posedge clk or negedge rst_sync_n_r) begin
      if (!rst_sync_n_r) begin
         state_r  <= IDLE;
         op_r     <= OP_LOAD;
         cnt_r    <= '0;
         wr_stb_r <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= next_state_s;
         op_r     <= op_next_s;
         cnt_r    <= cnt_next_s;
         wr_stb_r <= (next_state_s == COMMIT);
         busy_r   <= (next_state_s != IDLE);
      end
   end

   // bank registers, touched only in the single COMMIT cycle
   always_ff @(posedge clk or negedge rst_sync_n_r) begin
      if (!rst_sync_n_r) begin
         bank_x_r <= '0;
         bank_y_r <= '0;
         bank_z_r <= '0;
         bank_w_r <= '0;
      end else if (state_r == COMMIT) begin
         if (op_r == OP_CLR) begin
            bank_x_r <= '0;
            bank_y_r <= '0;
            bank_z_r <= '0;
            bank_w_r <= '0;
         end else begin
            case (sel_s)
               BANK_X:  bank_x_r <= d_s;
               BANK_Y:  bank_y_r <= d_s;
               BANK_Z:  bank_z_r <= d_s;
               BANK_W:  bank_w_r <= d_s;
               default: bank_x_r <= bank_x_r;
            endcase
         end
      end else begin
         bank_x_r <= bank_x_r;
      end
   end

   assign bus.X      = bank_x_r;
   assign bus.Y      = bank_y_r;
   assign bus.Z      = bank_z_r;
   assign bus.W      = bank_w_r;
   assign bus.S1LED  = sel_s[1];
   assign bus.S0LED  = sel_s[0];
   assign bus.WR_STB = wr_stb_r;
   assign bus.BUSY   = busy_r;

endmodule
